// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for its data-SRAM response, cancels stale responses after flush.
// Optional MEM_BYPASS_EN: forward ALU results to ID instead of stalling on every destination match.
module mem_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ECODE_W = 6,
    parameter int unsigned ESUB_W  = 9
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  ex_req_issued,
    input  logic [3*XLEN+ECODE_W+ESUB_W+16:0]     ex_bus,
    input  logic                                  data_sram_data_ok,
    input  logic [XLEN-1:0]                       data_sram_rdata,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [4*XLEN+ECODE_W+ESUB_W+16:0]     wb_bus,
    input  logic                                  flush,
    output logic                                  ms_ex_ertn,
    output logic                                  fwd_valid,
    output logic [4:0]                            fwd_dest,
    output logic [XLEN-1:0]                       fwd_data,
    output logic                                  fwd_blocked
);
    localparam int unsigned EX_W      = 3*XLEN + ECODE_W + ESUB_W + 17;
    // bus layout, MSB first: pc, result, mem_op, res_from_mem, gr_we, dest, has_exception, ecode, esubcode, maddr, ertn
    localparam int unsigned O_ERTN    = 0;
    localparam int unsigned O_HAS_EXC = 1 + XLEN + ESUB_W + ECODE_W;
    localparam int unsigned O_DEST    = O_HAS_EXC + 1;
    localparam int unsigned O_GR_WE   = O_DEST + 5;
`ifdef MEM_BYPASS_EN
    localparam int unsigned O_RFM     = O_GR_WE + 1;
    localparam int unsigned O_RES     = O_RFM + 9;
`endif

    logic            r_valid;
    logic            r_waiting;
    logic            r_buf_v;
    logic [1:0]      r_cancel;
    logic [EX_W-1:0] r_bus;
    logic [XLEN-1:0] r_buf;

    logic       w_ok_live;
    logic       w_ready_go;
    logic       w_accept;
    logic       w_hs;
    logic       w_dec;
    logic [1:0] w_inc;
    logic [2:0] w_cancel_nxt;
    logic       w_gr_we;
    logic [4:0] w_dest;

    assign w_ok_live  = data_sram_data_ok & (r_cancel == 2'd0);
    assign w_ready_go = ~r_waiting | w_ok_live;
    assign out_valid  = r_valid & w_ready_go & ~flush;
    assign in_ready   = resetn & ~flush & (~r_valid | (out_valid & out_ready));
    assign w_accept   = in_valid & in_ready;
    assign w_hs       = out_valid & out_ready;

    // A response arriving in the flush cycle already satisfies the held request, so it is not cancelled again.
    always_comb begin
        w_inc = 2'd0;
        w_dec = data_sram_data_ok & (r_cancel != 2'd0);
        if (flush) begin
            w_inc = 2'(r_waiting & ~w_ok_live) + 2'(in_valid & ex_req_issued);
        end
        w_cancel_nxt = 3'(r_cancel) + 3'(w_inc) - 3'(w_dec);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid   <= 1'b0;
            r_waiting <= 1'b0;
            r_buf_v   <= 1'b0;
            r_cancel  <= 2'd0;
            r_bus     <= '0;
            r_buf     <= '0;
        end else begin
            r_cancel <= w_cancel_nxt[1:0];
            if (flush) begin
                r_valid   <= 1'b0;
                r_waiting <= 1'b0;
                r_buf_v   <= 1'b0;
            end else if (w_accept) begin
                r_bus     <= ex_bus;
                r_valid   <= 1'b1;
                r_waiting <= ex_req_issued;
                r_buf_v   <= 1'b0;
            end else begin
                if (w_hs) begin
                    r_valid <= 1'b0;
                    r_buf_v <= 1'b0;
                end
                if (r_waiting && w_ok_live) begin
                    r_waiting <= 1'b0;
                    if (!out_ready) begin
                        r_buf   <= data_sram_rdata;
                        r_buf_v <= 1'b1;
                    end
                end
            end
        end
    end

    assign wb_bus     = {r_bus, (r_buf_v ? r_buf : data_sram_rdata)};
    assign ms_ex_ertn = r_valid & (r_bus[O_HAS_EXC] | r_bus[O_ERTN]);
    assign w_gr_we    = r_valid & r_bus[O_GR_WE];
    assign w_dest     = r_bus[O_DEST +: 5];
    assign fwd_dest   = w_gr_we ? w_dest : 5'd0;

`ifdef MEM_BYPASS_EN
    assign fwd_valid   = w_gr_we & ~r_bus[O_RFM];
    assign fwd_data    = r_bus[O_RES +: XLEN];
    assign fwd_blocked = w_gr_we & r_bus[O_RFM];
`else
    assign fwd_valid   = 1'b0;
    assign fwd_data    = '0;
    assign fwd_blocked = w_gr_we & (w_dest != 5'd0);
`endif

`ifndef SYNTHESIS
    a_no_cancel_sat: assert property (@(posedge clk) disable iff (!resetn) w_cancel_nxt <= 3'd3);
    a_no_stray_ok:   assert property (@(posedge clk) disable iff (!resetn)
                                      !(data_sram_data_ok && r_cancel == 2'd0 && !r_waiting));
`endif
endmodule
